jtag_tap_target: RTL and testbench

JTAG_TAP_TARGET -- requirements
Module: jtag_tap_target

---
 rtl/jtag_pkg.sv | 57 +++++
 rtl/jtag_tap_target_if.sv | 13 +
 rtl/jtag_sync.sv | 27 ++
 rtl/jtag_tap_target.sv | 151 +++++++++++++++
 tb/tb_jtag_tap_target.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: shared types and constants for the JTAG TAP target.
//   tap_state_t : 16 TAP states with IEEE 1149.1 encoding
//   OP_*        : instruction opcodes (IDCODE, USER, BYPASS)
//   USER_W      : USER data register width
//   tap_next()  : TAP next-state function
package jtag_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_IDLE         = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_USER} dr_sel_t;

  localparam logic [3:0] OP_IDCODE = 4'h1;
  localparam logic [3:0] OP_USER   = 4'h2;
  localparam logic [3:0] OP_BYPASS = 4'hF;
  localparam int         USER_W    = 8;
  localparam int         IDCODE_W  = 32;

  function automatic tap_state_t tap_next(tap_state_t s, logic tms);
    case (s)
      TEST_LOGIC_RESET: return tms ? TEST_LOGIC_RESET : RUN_IDLE;
      RUN_IDLE:         return tms ? SELECT_DR : RUN_IDLE;
      SELECT_DR:        return tms ? SELECT_IR : CAPTURE_DR;
      SELECT_IR:        return tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_DR:       return tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR:         return tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR:         return tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         return tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR:         return tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        return tms ? SELECT_DR : RUN_IDLE;
      CAPTURE_IR:       return tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR:         return tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR:         return tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         return tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR:         return tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        return tms ? SELECT_DR : RUN_IDLE;
      default:          return TEST_LOGIC_RESET;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_target_if.sv
// jtag_tap_target_if: JTAG pin bundle.
//   TCK/TMS/TDI : master -> target, asynchronous to the target clock
//   TDO/tdo_oe  : target -> master
interface jtag_tap_target_if;
  logic TCK;
  logic TMS;
  logic TDI;
  logic TDO;
  logic tdo_oe;

  modport master (output TCK, TMS, TDI, input  TDO, tdo_oe);
  modport slave  (input  TCK, TMS, TDI, output TDO, tdo_oe);
endinterface

// File: rtl/jtag_sync.sv
// jtag_sync: single-bit STAGES-flop synchronizer, cleared on reset.
//   clk, rst_n : system clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronized output (STAGES clk latency)
module jtag_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/jtag_tap_target.sv
// jtag_tap_target: IEEE 1149.1 TAP target oversampled on the system clock.
//   clk, rst_n  : system clock, async active-low reset
//   jtag        : TCK/TMS/TDI in, TDO/tdo_oe out (tdo_oe high in Shift-IR/DR)
//   tap_state   : current TAP state (IEEE encoding)
//   user_dr     : last value committed to the 8-bit USER register
//   user_update : one-clk pulse when user_dr is written
// Instructions: IDCODE (32b), USER (8b), anything else BYPASS (1b).
module jtag_tap_target
  import jtag_pkg::*;
#(
  parameter int          IR_LEN      = 4,
  parameter logic [31:0] IDCODE_VAL  = 32'h1BADC0DF,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  jtag_tap_target_if.slave  jtag,
  output logic [3:0]        tap_state,
  output logic [USER_W-1:0] user_dr,
  output logic              user_update
);

  // pin synchronizers: lane 0 TCK, lane 1 TMS, lane 2 TDI
  logic [2:0] pin_raw, pin_s;
  assign pin_raw = {jtag.TDI, jtag.TMS, jtag.TCK};

  for (genvar g = 0; g < 3; g++) begin : g_sync
    jtag_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pin_raw[g]),
      .q     (pin_s[g])
    );
  end

  logic tck_s, tms_s, tdi_s;
  assign tck_s = pin_s[0];
  assign tms_s = pin_s[1];
  assign tdi_s = pin_s[2];

  // vld_pipe tracks when the synchronizer output holds a real pin sample
  // rather than its reset value. Edges are only accepted once TCK has been
  // genuinely seen low, so a TCK held high across reset release is not a rise.
  logic [SYNC_STAGES-1:0] vld_pipe;
  logic                   armed, tck_d;
  logic                   rise, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      armed    <= 1'b0;
      tck_d    <= 1'b0;
    end else begin
      vld_pipe[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      armed <= armed | (vld_pipe[SYNC_STAGES-1] & ~tck_s);
      tck_d <= tck_s;
    end
  end

  assign rise = armed &  tck_s & ~tck_d;
  assign fall = armed & ~tck_s &  tck_d;

  tap_state_t          state;
  logic [IR_LEN-1:0]   ir, ir_sh;
  logic [IDCODE_W-1:0] id_sh;
  logic [USER_W-1:0]   usr_sh;
  logic                byp_sh, tdo_q;
  dr_sel_t             dr_sel;
  logic                dr_lsb;

  always_comb begin
    dr_sel = SEL_BYPASS;
    case (ir)
      IR_LEN'(OP_IDCODE): dr_sel = SEL_IDCODE;
      IR_LEN'(OP_USER):   dr_sel = SEL_USER;
      IR_LEN'(OP_BYPASS): dr_sel = SEL_BYPASS;
      default:            dr_sel = SEL_BYPASS;
    endcase
  end

  always_comb begin
    dr_lsb = byp_sh;
    case (dr_sel)
      SEL_IDCODE: dr_lsb = id_sh[0];
      SEL_USER:   dr_lsb = usr_sh[0];
      default:    dr_lsb = byp_sh;
    endcase
  end

  // Capture/shift act on TCK rise in the state being left; TDO and the
  // update actions act on TCK fall in the state just entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= TEST_LOGIC_RESET;
      ir          <= IR_LEN'(OP_IDCODE);
      ir_sh       <= '0;
      id_sh       <= '0;
      usr_sh      <= '0;
      byp_sh      <= 1'b0;
      user_dr     <= '0;
      user_update <= 1'b0;
      tdo_q       <= 1'b0;
    end else begin
      user_update <= 1'b0;
      if (rise) begin
        case (state)
          TEST_LOGIC_RESET: ir <= IR_LEN'(OP_IDCODE);
          CAPTURE_IR:       ir_sh <= IR_LEN'(1);  // {zeros, 2'b01}
          SHIFT_IR:         ir_sh <= {tdi_s, ir_sh[IR_LEN-1:1]};
          CAPTURE_DR: begin
            case (dr_sel)
              SEL_IDCODE: id_sh  <= IDCODE_VAL;
              SEL_USER:   usr_sh <= user_dr;
              default:    byp_sh <= 1'b0;
            endcase
          end
          SHIFT_DR: begin
            case (dr_sel)
              SEL_IDCODE: id_sh  <= {tdi_s, id_sh[IDCODE_W-1:1]};
              SEL_USER:   usr_sh <= {tdi_s, usr_sh[USER_W-1:1]};
              default:    byp_sh <= tdi_s;
            endcase
          end
          default: ;
        endcase
        state <= tap_next(state, tms_s);
      end
      if (fall) begin
        tdo_q <= 1'b0;
        case (state)
          SHIFT_IR:  tdo_q <= ir_sh[0];
          SHIFT_DR:  tdo_q <= dr_lsb;
          UPDATE_IR: ir <= ir_sh;
          UPDATE_DR: begin
            if (dr_sel == SEL_USER) begin
              user_dr     <= usr_sh;
              user_update <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign tap_state   = state;
  assign jtag.TDO    = tdo_q;
  assign jtag.tdo_oe = (state == SHIFT_IR) || (state == SHIFT_DR);

endmodule

// File: tb/tb_jtag_tap_target.sv
// tb_jtag_tap_target: directed + randomized bench for jtag_tap_target.
// The reference model keeps shift registers as bit queues (LSB at the
// front), advanced once per TCK cycle; every TCK cycle compares state,
// TDO, tdo_oe, user_dr and the count of user_update pulses.
module tb_jtag_tap_target;
  import jtag_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] tap_state;
  logic [7:0] user_dr;
  logic       user_update;

  jtag_tap_target_if jif();

  jtag_tap_target dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .jtag        (jif),
    .tap_state   (tap_state),
    .user_dr     (user_dr),
    .user_update (user_update)
  );

  always #5 clk = ~clk;

  int upd_cnt = 0;
  always @(posedge clk) if (rst_n && user_update) upd_cnt <= upd_cnt + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  tap_state_t m_st;
  logic [3:0] m_ir;
  bit         m_irq[$];
  bit         m_drq[$];
  logic [7:0] m_user;
  int         m_upd = 0;
  logic       m_tdo;

  function automatic tap_state_t ref_next(tap_state_t s, bit tms);
    case (s)
      TEST_LOGIC_RESET: return tms ? TEST_LOGIC_RESET : RUN_IDLE;
      RUN_IDLE:         return tms ? SELECT_DR : RUN_IDLE;
      SELECT_DR:        return tms ? SELECT_IR : CAPTURE_DR;
      SELECT_IR:        return tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_DR, SHIFT_DR: return tms ? EXIT1_DR : SHIFT_DR;
      CAPTURE_IR, SHIFT_IR: return tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_DR:         return tms ? UPDATE_DR : PAUSE_DR;
      EXIT1_IR:         return tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_DR:         return tms ? EXIT2_DR : PAUSE_DR;
      PAUSE_IR:         return tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_DR:         return tms ? UPDATE_DR : SHIFT_DR;
      EXIT2_IR:         return tms ? UPDATE_IR : SHIFT_IR;
      default:          return tms ? SELECT_DR : RUN_IDLE;  // both Update states
    endcase
  endfunction

  function automatic void model_reset();
    m_st = TEST_LOGIC_RESET;
    m_ir = 4'h1;
    m_irq.delete();
    m_drq.delete();
    m_user = 8'h00;
    m_tdo = 1'b0;
  endfunction

  function automatic void load_dr(logic [31:0] v, int w);
    m_drq.delete();
    for (int i = 0; i < w; i++) m_drq.push_back(v[i]);
  endfunction

  function automatic logic [31:0] pack_dr();
    logic [31:0] v = '0;
    for (int i = 0; i < m_drq.size(); i++) v[i] = m_drq[i];
    return v;
  endfunction

  function automatic logic [31:0] pack_ir();
    logic [31:0] v = '0;
    for (int i = 0; i < m_irq.size(); i++) v[i] = m_irq[i];
    return v;
  endfunction

  function automatic void model_step(bit tms, bit tdi);
    case (m_st)
      TEST_LOGIC_RESET: m_ir = 4'h1;
      CAPTURE_IR: begin
        m_irq.delete();
        m_irq.push_back(1'b1);
        for (int i = 1; i < 4; i++) m_irq.push_back(1'b0);
      end
      SHIFT_IR: begin void'(m_irq.pop_front()); m_irq.push_back(tdi); end
      CAPTURE_DR: begin
        if (m_ir == 4'h1)      load_dr(32'h1BADC0DF, 32);
        else if (m_ir == 4'h2) load_dr({24'h0, m_user}, 8);
        else                   load_dr(32'h0, 1);
      end
      SHIFT_DR: begin void'(m_drq.pop_front()); m_drq.push_back(tdi); end
      default: ;
    endcase
    m_st = ref_next(m_st, tms);
    if (m_st == UPDATE_IR) m_ir = pack_ir();
    if (m_st == UPDATE_DR && m_ir == 4'h2) begin
      m_user = pack_dr();
      m_upd++;
    end
    if (m_st == SHIFT_IR)      m_tdo = m_irq[0];
    else if (m_st == SHIFT_DR) m_tdo = m_drq[0];
    else                       m_tdo = 1'b0;
  endfunction

  task automatic check_outputs();
    chk("state",   tap_state, m_st);
    chk("tdo",     jif.TDO, m_tdo);
    chk("tdo_oe",  jif.tdo_oe, (m_st == SHIFT_DR || m_st == SHIFT_IR));
    chk("user_dr", user_dr, m_user);
    chk("upd_cnt", upd_cnt, m_upd);
  endtask

  // ---------------- JTAG driving ----------------
  // One TCK period (200 ns = 20 clk); tdo_pre is TDO just before the rise.
  task automatic tck_cycle(input bit tms, input bit tdi, output logic tdo_pre);
    jif.TMS = tms;
    jif.TDI = tdi;
    #40;
    tdo_pre = jif.TDO;
    jif.TCK = 1'b1;
    #80;
    jif.TCK = 1'b0;
    #80;
    model_step(tms, tdi);
    check_outputs();
  endtask

  logic b;

  task automatic cyc(input bit tms);
    logic t;
    tck_cycle(tms, 1'($urandom_range(0, 1)), t);
  endtask

  task automatic goto_tlr();
    repeat (5) cyc(1'b1);
  endtask

  // Enter in a Shift state; leaves in Exit1 after n shifts.
  task automatic shift_bits(input int n, input logic [31:0] din, output logic [31:0] dout);
    logic t;
    dout = '0;
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], t);
      dout[i] = t;
    end
  endtask

  task automatic load_ir(input logic [3:0] v, output logic [31:0] cap);
    goto_tlr();
    cyc(1'b0); cyc(1'b1); cyc(1'b1); cyc(1'b0); cyc(1'b0);
    shift_bits(4, {28'h0, v}, cap);
    cyc(1'b1); cyc(1'b0);
  endtask

  task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout);
    cyc(1'b1); cyc(1'b0); cyc(1'b0);
    shift_bits(n, din, dout);
    cyc(1'b1); cyc(1'b0);
  endtask

  logic [31:0] d, c;
  logic [3:0]  op;
  int          u0;

  initial begin
    rst_n = 1'b0;
    jif.TCK = 1'b0;
    jif.TMS = 1'b1;
    jif.TDI = 1'b0;
    model_reset();
    @(negedge clk);

    // reset holds with TCK toggling
    repeat (4) begin #40 jif.TCK = ~jif.TCK; end
    #40;
    chk("rst_state", tap_state, 4'hF);
    chk("rst_tdo", jif.TDO, 1'b0);
    chk("rst_oe", jif.tdo_oe, 1'b0);
    chk("rst_user", user_dr, 8'h00);

    // TCK already high at release must not count as a rise
    jif.TCK = 1'b1;
    jif.TMS = 1'b0;
    #40 rst_n = 1'b1;
    #200;
    chk("no_rise_after_rst", tap_state, 4'hF);
    jif.TCK = 1'b0;
    #80;
    tck_cycle(1'b0, 1'b0, b);  // first real rise -> RTI

    // reset in the middle of a USER shift
    load_ir(4'h2, c);
    cyc(1'b1); cyc(1'b0); cyc(1'b0);
    repeat (3) tck_cycle(1'b0, 1'b1, b);
    #40 rst_n = 1'b0;
    #40 rst_n = 1'b1;
    #100;
    model_reset();
    chk("mid_rst_state", tap_state, 4'hF);
    chk("mid_rst_user", user_dr, 8'h00);
    chk("mid_rst_upd", upd_cnt, 0);
    repeat (3) cyc(1'b1);

    // IDCODE read straight from TLR
    goto_tlr();
    cyc(1'b0); cyc(1'b1); cyc(1'b0); cyc(1'b0);
    shift_bits(32, $urandom, d);
    chk("idcode", d, 32'h1BADC0DF);
    cyc(1'b1); cyc(1'b0);

    // BYPASS: IR capture pattern, then 1-bit delayed echo
    load_ir(4'hF, c);
    chk("ir_capture", c, 32'h1);
    dr_scan(8, 32'hA5, d);
    chk("bypass", d, 32'h4A);

    // USER write, pulse width, re-read
    load_ir(4'h2, c);
    u0 = upd_cnt;
    dr_scan(8, 32'h3C, d);
    chk("user_write", user_dr, 8'h3C);
    chk("user_pulse", upd_cnt - u0, 1);
    dr_scan(8, 32'h00, d);
    chk("user_reread", d, 32'h3C);

    // TLR escape from Shift-DR, IR forced back to IDCODE
    load_ir(4'h2, c);
    cyc(1'b1); cyc(1'b0); cyc(1'b0);
    repeat (5) cyc(1'b1);
    chk("tlr_escape", tap_state, 4'hF);
    cyc(1'b0);
    dr_scan(32, $urandom, d);
    chk("tlr_ir_idcode", d, 32'h1BADC0DF);

    // randomized instruction/data scans
    for (int k = 0; k < 15; k++) begin
      case ($urandom_range(0, 3))
        0:       op = 4'h1;
        1:       op = 4'h2;
        2:       op = 4'hF;
        default: op = 4'($urandom_range(0, 15));
      endcase
      load_ir(op, c);
      chk("rnd_ir_capture", c, 32'h1);
      dr_scan($urandom_range(1, 32), $urandom, d);
    end

    // random TMS walk (pause/exit2 paths included)
    for (int k = 0; k < 200; k++)
      tck_cycle($urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)), b);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
